// File: rtl/wb_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  localparam int NUM_M = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_M-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (oh[i]) onehot_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between four Wishbone masters, the arbiter and one shared slave.
// Handshake: a master holds m_cyc_i for its whole bus cycle; a beat completes on a
// cycle where the owner has m_stb_i high and the slave returns s_ack_i (ack forwarded only to the owner).
interface wb_rr_arbiter_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [3:0]        m_cyc_i;
  logic [3:0]        m_stb_i;
  logic [3:0]        m_we_i;
  logic [4*aw-1:0]   m_adr_i;
  logic [4*dw-1:0]   m_dat_i;
  logic [4*dw/8-1:0] m_sel_i;
  logic [dw-1:0]     m_dat_o;
  logic [3:0]        m_ack_o;
  logic [3:0]        m_err_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [aw-1:0]     s_adr_o;
  logic [dw-1:0]     s_dat_o;
  logic [dw/8-1:0]   s_sel_o;
  logic [dw-1:0]     s_dat_i;
  logic              s_ack_i;
  logic [3:0]        grant_o;

  // Arbiter's view.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, grant_o
  );

  // Environment's view: the masters plus the shared slave device.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, grant_o
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr.
module rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM_M-1:0] gnt
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is assigned last and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Four-master Wishbone round-robin arbiter with registered one-hot grant.
// Define WB_ARB_TIMEOUT_EN to add the unacknowledged-strobe watchdog and ABORT state.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int timeout = 255
) (
  input  logic            clk,
  input  logic            rst,
  wb_rr_arbiter_if.slave  bus,
  output arb_state_t      state_o
);

  localparam int SW = dw / 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(timeout - 1);

  arb_state_t       state, state_nxt;
  logic [NUM_M-1:0] grant, grant_nxt, win;
  logic [IDX_W-1:0] owner, owner_nxt, ptr, ptr_nxt;
  logic             owner_cyc, owner_stb, arbitrate, slave_live;

  rr_pick u_pick (
    .req (bus.m_cyc_i),
    .ptr (ptr),
    .gnt (win)
  );

  assign owner_cyc = bus.m_cyc_i[owner];
  assign owner_stb = bus.m_stb_i[owner];
  // The owner releasing cyc frees the bus in both OWN and ABORT.
  assign arbitrate = (state == ST_IDLE) || !owner_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_q, timeout_hit;

  assign timeout_hit = (state == ST_OWN) && owner_stb && !bus.s_ack_i && (cnt == TO_LAST);

  always_comb begin
    cnt_nxt = '0;
    if (!arbitrate && (state == ST_OWN) && owner_stb && !bus.s_ack_i) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      err_q <= (state_nxt == ST_ABORT) && (state != ST_ABORT);
    end
  end

  assign bus.m_err_o = grant & {NUM_M{err_q}};
`else
  assign bus.m_err_o = '0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    if (arbitrate) begin
      if (|bus.m_cyc_i) begin
        state_nxt = ST_OWN;
        grant_nxt = win;
        owner_nxt = onehot_idx(win);
        ptr_nxt   = onehot_idx(win) + IDX_W'(1);
      end else begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    else if (timeout_hit) begin
      state_nxt = ST_ABORT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign slave_live  = (state != ST_ABORT);
  assign state_o     = state;
  assign bus.grant_o = grant;

  assign bus.s_cyc_o = (|(bus.m_cyc_i & grant)) && slave_live;
  assign bus.s_stb_o = (|(bus.m_stb_i & grant)) && slave_live;
  assign bus.s_we_o  = bus.m_we_i[owner];
  assign bus.s_adr_o = bus.m_adr_i[int'(owner)*aw +: aw];
  assign bus.s_dat_o = bus.m_dat_i[int'(owner)*dw +: dw];
  assign bus.s_sel_o = bus.m_sel_i[int'(owner)*SW +: SW];

  assign bus.m_ack_o = grant & {NUM_M{bus.s_ack_i}};
  assign bus.m_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed table-driven bench for wb_rr_arbiter plus watchdog sequences.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  arb_state_t st;
  int         tests = 0;
  int         fails = 0;

  wb_rr_arbiter_if #(.dw(32), .aw(32)) bus ();

  wb_rr_arbiter #(.dw(32), .aw(32), .timeout(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] grant;
    logic [3:0] mack;
    logic       scyc;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic r, logic [3:0] c, logic a, logic [3:0] g, logic [3:0] m, logic s);
    vec_t v;
    v.rst = r; v.cyc = c; v.ack = a; v.grant = g; v.mack = m; v.scyc = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; outputs are sampled at the falling edge.
  task automatic step(input logic r, input logic [3:0] cyc, input logic [3:0] stb, input logic ack);
    @(posedge clk);
    #1;
    rst         = r;
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.s_ack_i = ack;
    bus.s_dat_i = $urandom;
    @(negedge clk);
  endtask

  function automatic logic [31:0] adr_of(input logic [3:0] g);
    logic [31:0] a;
    a = 32'hA000_0000;
    for (int i = 0; i < 4; i++) if (g[i]) a = 32'hA000_0000 + 32'(i);
    return a;
  endfunction

  logic [3:0] we_pat = 4'b1010;

  initial begin
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = we_pat;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    for (int i = 0; i < 4; i++) begin
      bus.m_adr_i[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      bus.m_dat_i[i*32 +: 32] = 32'h5000_0000 + 32'(i);
      bus.m_sel_i[i*4 +: 4]   = 4'(i + 1);
    end

    // Master 2 alone, ack on third owned cycle, then idle.
    tbl[0]  = mk(1, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    tbl[1]  = mk(1, 4'b0100, 0, 4'b0100, 4'b0000, 1);
    tbl[2]  = mk(1, 4'b0100, 0, 4'b0100, 4'b0000, 1);
    tbl[3]  = mk(1, 4'b0100, 1, 4'b0100, 4'b0100, 1);
    tbl[4]  = mk(1, 4'b0000, 0, 4'b0100, 4'b0000, 0);
    tbl[5]  = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    tbl[6]  = mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // All four requesting: 0,1,2,3,0 with no idle grant between owners.
    tbl[7]  = mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    tbl[8]  = mk(1, 4'b1111, 1, 4'b0001, 4'b0001, 1);
    tbl[9]  = mk(1, 4'b1110, 0, 4'b0001, 4'b0000, 0);
    tbl[10] = mk(1, 4'b1111, 1, 4'b0010, 4'b0010, 1);
    tbl[11] = mk(1, 4'b1101, 0, 4'b0010, 4'b0000, 0);
    tbl[12] = mk(1, 4'b1111, 1, 4'b0100, 4'b0100, 1);
    tbl[13] = mk(1, 4'b1011, 0, 4'b0100, 4'b0000, 0);
    tbl[14] = mk(1, 4'b1111, 1, 4'b1000, 4'b1000, 1);
    tbl[15] = mk(1, 4'b0111, 0, 4'b1000, 4'b0000, 0);
    // Owner 0 drops cyc in its ack cycle: ack still forwarded.
    tbl[16] = mk(1, 4'b0010, 1, 4'b0001, 4'b0001, 0);
    // Master 1 holds four beats while master 0 waits.
    tbl[17] = mk(1, 4'b0011, 1, 4'b0010, 4'b0010, 1);
    tbl[18] = mk(1, 4'b0011, 1, 4'b0010, 4'b0010, 1);
    tbl[19] = mk(1, 4'b0011, 1, 4'b0010, 4'b0010, 1);
    tbl[20] = mk(1, 4'b0011, 1, 4'b0010, 4'b0010, 1);
    tbl[21] = mk(1, 4'b0001, 0, 4'b0010, 4'b0000, 0);
    tbl[22] = mk(1, 4'b0001, 0, 4'b0001, 4'b0000, 1);
    // Reset mid-transfer, then master 3 alone.
    tbl[23] = mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    tbl[24] = mk(1, 4'b1000, 0, 4'b0000, 4'b0000, 0);
    tbl[25] = mk(1, 4'b1000, 0, 4'b1000, 4'b0000, 1);
    tbl[26] = mk(1, 4'b0000, 0, 4'b1000, 4'b0000, 0);
    tbl[27] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0);

    repeat (2) @(negedge clk);
    chk("reset grant", 32'(bus.grant_o), 32'h0);
    chk("reset s_cyc", 32'(bus.s_cyc_o), 32'h0);
    chk("reset state", 32'(st), 32'(ST_IDLE));

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst, tbl[i].cyc, tbl[i].cyc, tbl[i].ack);
      chk($sformatf("row%0d grant", i), 32'(bus.grant_o), 32'(tbl[i].grant));
      chk($sformatf("row%0d m_ack", i), 32'(bus.m_ack_o), 32'(tbl[i].mack));
      chk($sformatf("row%0d s_cyc", i), 32'(bus.s_cyc_o), 32'(tbl[i].scyc));
      chk($sformatf("row%0d s_stb", i), 32'(bus.s_stb_o), 32'(tbl[i].scyc));
      chk($sformatf("row%0d m_err", i), 32'(bus.m_err_o), 32'h0);
      chk($sformatf("row%0d m_dat", i), bus.m_dat_o, bus.s_dat_i);
      chk($sformatf("row%0d state", i), 32'(st),
          (tbl[i].grant == 4'b0000) ? 32'(ST_IDLE) : 32'(ST_OWN));
      if (tbl[i].grant != 4'b0000) begin
        chk($sformatf("row%0d s_adr", i), bus.s_adr_o, adr_of(tbl[i].grant));
        chk($sformatf("row%0d s_we", i), 32'(bus.s_we_o), 32'(|(we_pat & tbl[i].grant)));
      end
    end

    // Master 2 strobes, slave never acknowledges.
    step(0, 4'b0000, 4'b0000, 0);
    step(1, 4'b0100, 4'b0100, 0);
    chk("wd first grant", 32'(bus.grant_o), 32'h0);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step(1, 4'b0100, 4'b0100, 0);
      chk($sformatf("wd beat%0d m_err", k), 32'(bus.m_err_o), 32'h0);
      chk($sformatf("wd beat%0d s_stb", k), 32'(bus.s_stb_o), 32'h1);
    end
    step(1, 4'b0100, 4'b0100, 0);
    chk("wd abort m_err", 32'(bus.m_err_o), 32'h4);
    chk("wd abort s_stb", 32'(bus.s_stb_o), 32'h0);
    chk("wd abort s_cyc", 32'(bus.s_cyc_o), 32'h0);
    chk("wd abort state", 32'(st), 32'(ST_ABORT));
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b0100, 4'b0100, 0);
      chk($sformatf("wd hold%0d m_err", k), 32'(bus.m_err_o), 32'h0);
      chk($sformatf("wd hold%0d s_stb", k), 32'(bus.s_stb_o), 32'h0);
      chk($sformatf("wd hold%0d grant", k), 32'(bus.grant_o), 32'h4);
    end
    step(1, 4'b0000, 4'b0000, 0);
    chk("wd drop state", 32'(st), 32'(ST_ABORT));
    step(1, 4'b0000, 4'b0000, 0);
    chk("wd rearb grant", 32'(bus.grant_o), 32'h0);
    chk("wd rearb state", 32'(st), 32'(ST_IDLE));
`else
    begin
      int bad_err;
      bad_err = 0;
      for (int k = 0; k < 1000; k++) begin
        step(1, 4'b0100, 4'b0100, 0);
        if (bus.m_err_o != 4'b0000) bad_err++;
      end
      chk("nowd err cycles", 32'(bad_err), 32'h0);
      chk("nowd grant", 32'(bus.grant_o), 32'h4);
      chk("nowd s_stb", 32'(bus.s_stb_o), 32'h1);
      chk("nowd state", 32'(st), 32'(ST_OWN));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter dw, default 32, data width.
REQ-002 Parameter aw, default 32, address width.
REQ-003 Parameter timeout, default 255, cycle limit for an unacknowledged strobe, range 1..65535.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 m_cyc_i  in  4  per-master cycle request; master i is bit i.
REQ-007 m_stb_i / m_we_i  in  4 each  per-master strobe / write enable.
REQ-008 m_adr_i  in  4*aw  master i at bits [i*aw +: aw].
REQ-009 m_dat_i  in  4*dw  master i at bits [i*dw +: dw].
REQ-010 m_sel_i  in  4*(dw/8)  byte selects, packed like m_dat_i.
REQ-011 m_dat_o  out  dw  slave read data, broadcast to all masters.
REQ-012 m_ack_o / m_err_o  out  4 each  ack / error, owner bit only.
REQ-013 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
REQ-014 s_adr_o  out  aw  slave address.
REQ-015 s_dat_o  out  dw  slave write data.
REQ-016 s_sel_o  out  dw/8  slave byte selects.
REQ-017 s_dat_i / s_ack_i  in  dw / 1  slave read data / acknowledge.
REQ-018 grant_o  out  4  registered one-hot owner; 0 when none.

Function
REQ-019 FSM states: IDLE (no owner), OWN (grant held), ABORT (timeout recovery, present only with the macro).
REQ-020 Arbitration happens at a clock edge when the state is IDLE, or when the state is OWN and the owner's m_cyc_i is low.
- Winner is the first requester scanning from (last owner+1) mod 4 upward.
- Requests are any set bit in m_cyc_i.
- Grant is registered; it is visible one cycle after the request.
REQ-021 On a release edge with other requests pending, the FSM goes OWN->OWN with the new owner, with no idle cycle.
- With no requests pending, the FSM goes to IDLE and grant_o becomes 0.
REQ-022 The grant is held for as long as the owner keeps m_cyc_i high, whatever the other masters request; multi-beat and read-modify-write sequences therefore stay atomic.
REQ-023 Slave outputs mux the owner's signals combinationally.
- s_cyc_o and s_stb_o are ANDed with the grant, so they are 0 in IDLE and ABORT.
REQ-024 m_ack_o[i] = s_ack_i AND grant_o[i], combinational with zero added latency.
- m_dat_o = s_dat_i unconditionally.
REQ-025 The round-robin pointer updates only when a new grant is issued.
REQ-026 An ack in the same cycle that the owner drops m_cyc_i is still forwarded; the ownership change takes effect at that edge.
REQ-027 Requests from non-owners never reach the slave.

Reset
REQ-028 Asserting rst (low) immediately forces state IDLE and grant_o=0, and sets the pointer so that master 0 has highest priority.
- This drops s_cyc_o, s_stb_o, m_ack_o and m_err_o to 0 combinationally, including in the middle of a transfer.
REQ-029 In reset, s_adr_o, s_dat_o, s_sel_o and s_we_o reflect master 0's inputs; they are don't-care.

Configuration
REQ-030 Macro WB_ARB_TIMEOUT_EN controls the timeout watchdog.
REQ-031 With the macro defined: a 16-bit counter clears on any s_ack_i or while the owner's stb is low, and increments while the owner's stb is high and there is no ack.
- When it reaches timeout, the FSM goes to ABORT.
- In ABORT, m_err_o[owner] is asserted for exactly one cycle and the slave side is deasserted.
- The FSM stays in ABORT until the owner drops m_cyc_i, then re-arbitrates.
REQ-032 Without the macro: there is no counter and no ABORT state, m_err_o is tied to 0, and the grant can be held indefinitely.

Structure
REQ-033 Package wb_arb_pkg holds NUM_M=4, the state encoding (IDLE/OWN/ABORT) and the counter width constant.
REQ-034 The combinational round-robin picker is a separate sub-module, rr_pick (inputs req[3:0] and pointer; output one-hot winner).

Verification
REQ-035 Master 2 alone raises cyc/stb, slave acks after 3 cycles -> grant_o=4'b0100 one cycle later; m_ack_o=4'b0100 on the ack cycle.
REQ-036 All four request continuously, each releasing after one ack -> grants 0,1,2,3,0 in order, with no idle cycle between owners.
REQ-037 Master 1 holds cyc across 4 beats while master 0 requests -> grant_o stays 4'b0010 for all 4 beats, then 4'b0001.
REQ-038 rst pulsed low mid-transfer -> s_cyc_o=0 in the same cycle; after release with only master 3 requesting, grant_o=4'b1000.
REQ-039 Macro defined, timeout=8, slave never acks -> m_err_o[owner]=1 for one cycle after 8 strobe cycles; s_stb_o=0 until the owner drops cyc.
REQ-040 Macro undefined, same stimulus -> no error asserted; grant_o unchanged after 1000 cycles.
